// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO crossbar: FSM states, error codes,
// and the byte offsets of the error-register window.
package mmio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_INV_RD  = 2'd1;
  localparam logic [1:0] ERR_INV_WR  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int unsigned REG_ERRNO  = 0;
  localparam int unsigned REG_FADDR  = 4;
  localparam int unsigned REG_ERRCNT = 8;

endpackage

// File: rtl/mmio_decode.sv
// Combinational region decoder: address tag -> slave one-hot, slave hit, and
// error-register hit. Duplicate slave tags resolve to the lowest index.
module mmio_decode
  import mmio_pkg::*;
#(
  parameter int NUM_SLV = 8,
  parameter int TAG_W   = 12,
  parameter logic [NUM_SLV-1:0][TAG_W-1:0] SLV_TAG = '0,
  parameter logic [TAG_W-1:0] ERR_TAG = '1
) (
  input  logic [TAG_W-1:0]   i_tag,
  output logic               o_hit,
  output logic [NUM_SLV-1:0] o_sel,
  output logic               o_err_hit
);

  // Error window takes priority so its registers stay reachable even if a
  // slave tag aliases it; the descending scan leaves the lowest match.
  always_comb begin
    o_err_hit = (i_tag == ERR_TAG);
    o_hit     = 1'b0;
    o_sel     = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (!o_err_hit && (i_tag == SLV_TAG[i])) begin
        o_sel    = '0;
        o_sel[i] = 1'b1;
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_xbar.sv
// Single-master MMIO crossbar: decodes the address tag, forwards to one slave
// with an ack timeout, and serves a small sticky error-register window.
module mmio_xbar
  import mmio_pkg::*;
#(
  parameter int NUM_SLV = 8,
  parameter int TAG_W   = 12,
  parameter logic [NUM_SLV-1:0][TAG_W-1:0] SLV_TAG = {
    12'h007, 12'h006, 12'h005, 12'h004, 12'h003, 12'h002, 12'h001, 12'h000},
  parameter logic [TAG_W-1:0] ERR_TAG = 12'hFFF,
  parameter int TIMEOUT = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    m_req_valid,
  output logic                    m_req_ready,
  input  logic [31:0]             m_addr,
  input  logic [31:0]             m_wdata,
  input  logic                    m_we,
  input  logic [2:0]              m_op,
  output logic                    m_rsp_valid,
  output logic                    m_err,
  output logic [31:0]             m_rdata,
  output logic [NUM_SLV-1:0]      s_req_valid,
  output logic [31:0]             s_addr,
  output logic [31:0]             s_wdata,
  output logic                    s_we,
  output logic [2:0]              s_op,
  input  logic [NUM_SLV-1:0]      s_ack,
  input  logic [NUM_SLV-1:0][31:0] s_rdata,
  output logic                    irq_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int OFF_W = 32 - TAG_W;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_SLV-1:0]   r_sel;
  logic [NUM_SLV-1:0]   r_s_req_valid;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic                 r_we;
  logic [2:0]           r_op;
  logic                 r_reg_pend;
  logic                 r_m_rsp_valid;
  logic                 r_m_err;
  logic [31:0]          r_m_rdata;
  logic [1:0]           r_errno;
  logic [31:0]          r_faddr;
  logic [7:0]           r_err_cnt;

  logic                 w_hit;
  logic                 w_err_hit;
  logic [NUM_SLV-1:0]   w_sel;
  logic                 w_ack;
  logic [31:0]          w_rdata;
  logic [31:0]          w_reg_rdata;
  logic [OFF_W-1:0]     w_off;
  logic                 w_err_ev;
  logic [1:0]           w_err_code;
  logic [31:0]          w_err_addr;
  logic                 w_clr;

  mmio_decode #(
    .NUM_SLV (NUM_SLV),
    .TAG_W   (TAG_W),
    .SLV_TAG (SLV_TAG),
    .ERR_TAG (ERR_TAG)
  ) u_decode (
    .i_tag     (m_addr[31 -: TAG_W]),
    .o_hit     (w_hit),
    .o_sel     (w_sel),
    .o_err_hit (w_err_hit)
  );

  assign m_req_ready = (r_state == ST_IDLE);
  assign m_rsp_valid = r_m_rsp_valid;
  assign m_err       = r_m_err;
  assign m_rdata     = r_m_rdata;
  assign s_req_valid = r_s_req_valid;
  assign s_addr      = r_addr;
  assign s_wdata     = r_wdata;
  assign s_we        = r_we;
  assign s_op        = r_op;
  assign irq_err     = (r_errno != ERR_NONE);

  assign w_ack = |(s_ack & r_sel);
  assign w_off = r_addr[OFF_W-1:0];

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (r_sel[i]) w_rdata = w_rdata | s_rdata[i];
  end

  always_comb begin
    w_reg_rdata = '0;
    if (!r_we) begin
      if (w_off == OFF_W'(REG_ERRNO))       w_reg_rdata = {30'b0, r_errno};
      else if (w_off == OFF_W'(REG_FADDR))  w_reg_rdata = r_faddr;
      else if (w_off == OFF_W'(REG_ERRCNT)) w_reg_rdata = {24'b0, r_err_cnt};
    end
  end

  // Error events and the clear strobe, one source per FSM state.
  always_comb begin
    w_err_ev   = 1'b0;
    w_err_code = ERR_NONE;
    w_err_addr = r_addr;
    w_clr      = 1'b0;
    case (r_state)
      ST_IDLE: if (m_req_valid && !w_hit && !w_err_hit) begin
        w_err_ev   = 1'b1;
        w_err_code = m_we ? ERR_INV_WR : ERR_INV_RD;
        w_err_addr = m_addr;
      end
      ST_WAIT: if (!w_ack && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
        w_err_ev   = 1'b1;
        w_err_code = ERR_TIMEOUT;
      end
      ST_RESP: w_clr = r_reg_pend && r_we && (w_off == OFF_W'(REG_ERRNO));
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_errno   <= ERR_NONE;
      r_faddr   <= '0;
      r_err_cnt <= '0;
    end else if (w_err_ev) begin
      if (r_errno == ERR_NONE) begin
        r_errno <= w_err_code;
        r_faddr <= w_err_addr;
      end
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end else if (w_clr) begin
      r_errno <= ERR_NONE;
      r_faddr <= '0;
    end
  end

  // Error-window accesses spend their first RESP cycle reading the registers
  // so their latency matches a slave acking in its first WAIT cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_sel         <= '0;
      r_s_req_valid <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_we          <= 1'b0;
      r_op          <= '0;
      r_reg_pend    <= 1'b0;
      r_m_rsp_valid <= 1'b0;
      r_m_err       <= 1'b0;
      r_m_rdata     <= '0;
    end else begin
      r_s_req_valid <= '0;
      case (r_state)
        ST_IDLE: if (m_req_valid) begin
          r_addr  <= m_addr;
          r_wdata <= m_wdata;
          r_we    <= m_we;
          r_op    <= m_op;
          r_cnt   <= '0;
          r_sel   <= w_sel;
          if (w_err_hit) begin
            r_reg_pend <= 1'b1;
            r_state    <= ST_RESP;
          end else if (w_hit) begin
            r_s_req_valid <= w_sel;
            r_state       <= ST_WAIT;
          end else begin
            r_m_rsp_valid <= 1'b1;
            r_m_err       <= 1'b1;
            r_m_rdata     <= '0;
            r_state       <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (w_ack) begin
            r_m_rsp_valid <= 1'b1;
            r_m_err       <= 1'b0;
            r_m_rdata     <= r_we ? 32'h0 : w_rdata;
            r_state       <= ST_RESP;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_m_rsp_valid <= 1'b1;
            r_m_err       <= 1'b1;
            r_m_rdata     <= '0;
            r_state       <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (r_reg_pend) begin
            r_reg_pend    <= 1'b0;
            r_m_rsp_valid <= 1'b1;
            r_m_err       <= 1'b0;
            r_m_rdata     <= w_reg_rdata;
          end else begin
            r_m_rsp_valid <= 1'b0;
            r_m_err       <= 1'b0;
            r_m_rdata     <= '0;
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_xbar.sv
// Directed bench for mmio_xbar: slave paths, error window, timeout, counter
// saturation and reset mid-transaction, with hand-computed expectations.
module tb_mmio_xbar;

  localparam int NS = 8;
  localparam logic [NS-1:0][11:0] TAGS = {
    12'h007, 12'h006, 12'h002, 12'h004, 12'h003, 12'h002, 12'h001, 12'h000};

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic m_req_valid = 1'b0;
  logic m_req_ready;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic m_we = 1'b0;
  logic [2:0] m_op = '0;
  logic m_rsp_valid, m_err, irq_err;
  logic [31:0] m_rdata;
  logic [NS-1:0] s_req_valid;
  logic [31:0] s_addr, s_wdata;
  logic s_we;
  logic [2:0] s_op;
  logic [NS-1:0] s_ack = '0;
  logic [NS-1:0][31:0] s_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mmio_xbar #(.NUM_SLV(NS), .TAG_W(12), .SLV_TAG(TAGS), .ERR_TAG(12'hFFF), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_op(m_op),
    .m_rsp_valid(m_rsp_valid), .m_err(m_err), .m_rdata(m_rdata),
    .s_req_valid(s_req_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_we(s_we), .s_op(s_op), .s_ack(s_ack), .s_rdata(s_rdata),
    .irq_err(irq_err)
  );

  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] d);
    @(negedge clock);
    m_addr = a; m_we = we; m_wdata = d; m_op = 3'd5; m_req_valid = 1'b1;
    @(posedge clock);
    #1 m_req_valid = 1'b0;
  endtask

  // Returns the negedge index (1 = first cycle after acceptance) of the
  // response, or 0 if none arrived within max cycles.
  task automatic wait_rsp(input int max, output int cyc);
    cyc = 0;
    for (int k = 1; k <= max; k++) begin
      @(negedge clock);
      if (m_rsp_valid) begin cyc = k; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({m_req_ready, s_req_valid, m_rsp_valid, m_err, irq_err} !== {1'b1, 8'h00, 3'b000}) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy=%b sv=%h rv=%b err=%b irq=%b want rdy=1 others 0",
               m_req_ready, s_req_valid, m_rsp_valid, m_err, irq_err);
    end
    checks++;
    if (m_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
    reset = 1'b0;
  endtask

  task automatic test_errcnt_initial;
    int cyc;
    issue(32'hFFF00008, 1'b0, 32'h0);
    wait_rsp(5, cyc);
    checks++;
    if (cyc !== 2) begin errors++; $display("FAIL errreg_latency: got %0d want 2", cyc); end
    checks++;
    if ({m_err, m_rdata} !== {1'b0, 32'h0}) begin
      errors++; $display("FAIL errcnt_reset: got err=%b data=%h want 0/0", m_err, m_rdata);
    end
  endtask

  task automatic test_slave_read;
    issue(32'h00200040, 1'b0, 32'h0);
    @(negedge clock);
    checks++;
    if ({s_req_valid, s_addr, s_we, s_op} !== {8'h04, 32'h00200040, 1'b0, 3'd5}) begin
      errors++; $display("FAIL rd_req: got sv=%h a=%h we=%b op=%0d want 04/00200040/0/5",
                         s_req_valid, s_addr, s_we, s_op);
    end
    s_rdata[2] = 32'hDEADBEEF; s_ack[2] = 1'b1;
    @(negedge clock);
    s_ack = '0;
    checks++;
    if ({m_rsp_valid, m_err, m_rdata} !== {2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_rsp: got v=%b e=%b d=%h want 1/0/deadbeef", m_rsp_valid, m_err, m_rdata);
    end
    @(negedge clock);
    checks++;
    if ({m_rsp_valid, m_req_ready} !== 2'b01) begin
      errors++; $display("FAIL rd_single: got v=%b rdy=%b want 0/1", m_rsp_valid, m_req_ready);
    end
  endtask

  task automatic test_slave_write;
    int cyc;
    issue(32'h00100008, 1'b1, 32'h12345678);
    @(negedge clock);
    checks++;
    if ({s_req_valid, s_we, s_wdata} !== {8'h02, 1'b1, 32'h12345678}) begin
      errors++; $display("FAIL wr_req: got sv=%h we=%b wd=%h want 02/1/12345678", s_req_valid, s_we, s_wdata);
    end
    @(negedge clock);
    checks++;
    if ({s_req_valid, m_rsp_valid, s_wdata} !== {8'h00, 1'b0, 32'h12345678}) begin
      errors++; $display("FAIL wr_hold: got sv=%h v=%b wd=%h want 00/0/12345678", s_req_valid, m_rsp_valid, s_wdata);
    end
    s_rdata[1] = 32'hFFFFFFFF; s_ack[1] = 1'b1;
    wait_rsp(3, cyc);
    s_ack = '0;
    checks++;
    if ({cyc[3:0], m_err, m_rdata} !== {4'd1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL wr_rsp: got cyc=%0d e=%b d=%h want 1/0/0", cyc, m_err, m_rdata);
    end
  endtask

  task automatic test_select_only;
    int cyc;
    issue(32'h00300000, 1'b0, 32'h0);
    @(negedge clock);
    s_ack = 8'h04;
    @(negedge clock);
    checks++;
    if (m_rsp_valid !== 1'b0) begin errors++; $display("FAIL sel_ignore: got v=%b want 0", m_rsp_valid); end
    s_ack = 8'h08; s_rdata[3] = 32'hCAFEF00D;
    wait_rsp(3, cyc);
    s_ack = '0;
    checks++;
    if ({cyc[3:0], m_err, m_rdata} !== {4'd1, 1'b0, 32'hCAFEF00D}) begin
      errors++; $display("FAIL sel_rsp: got cyc=%0d e=%b d=%h want 1/0/cafef00d", cyc, m_err, m_rdata);
    end
  endtask

  task automatic test_unmapped;
    int cyc;
    issue(32'h9AB00010, 1'b1, 32'h55AA55AA);
    wait_rsp(4, cyc);
    checks++;
    if ({cyc[3:0], m_err, m_rdata} !== {4'd1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL miss_wr: got cyc=%0d e=%b d=%h want 1/1/0", cyc, m_err, m_rdata);
    end
    checks++;
    if (irq_err !== 1'b1) begin errors++; $display("FAIL miss_irq: got %b want 1", irq_err); end
    issue(32'h00500000, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if ({cyc[3:0], m_err} !== {4'd1, 1'b1}) begin
      errors++; $display("FAIL miss_dup_tag: got cyc=%0d e=%b want 1/1", cyc, m_err);
    end
    issue(32'hFFF00000, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if ({cyc[3:0], m_err, m_rdata} !== {4'd2, 1'b0, 32'd2}) begin
      errors++; $display("FAIL errno_wr: got cyc=%0d e=%b d=%h want 2/0/2", cyc, m_err, m_rdata);
    end
    issue(32'hFFF00004, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if (m_rdata !== 32'h9AB00010) begin errors++; $display("FAIL faddr: got %h want 9ab00010", m_rdata); end
    issue(32'hFFF00008, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if (m_rdata !== 32'd2) begin errors++; $display("FAIL errcnt_two: got %0d want 2", m_rdata); end
  endtask

  task automatic test_timeout;
    int cyc;
    bit extra;
    issue(32'hFFF00000, 1'b1, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if ({m_rdata, irq_err} !== {32'h0, 1'b0}) begin
      errors++; $display("FAIL clear1: got d=%h irq=%b want 0/0", m_rdata, irq_err);
    end
    issue(32'h00400000, 1'b0, 32'h0);
    wait_rsp(30, cyc);
    checks++;
    if ({cyc[7:0], m_err, m_rdata} !== {8'd16, 1'b1, 32'h0}) begin
      errors++; $display("FAIL timeout_rsp: got cyc=%0d e=%b d=%h want 16/1/0", cyc, m_err, m_rdata);
    end
    s_ack[4] = 1'b1; s_rdata[4] = 32'h11111111;
    extra = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (m_rsp_valid) extra = 1'b1;
    end
    s_ack = '0;
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL late_ack: got extra response want none"); end
    issue(32'hFFF00000, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if ({m_rdata, irq_err} !== {32'd3, 1'b1}) begin
      errors++; $display("FAIL errno_to: got d=%h irq=%b want 3/1", m_rdata, irq_err);
    end
    issue(32'hFFF00008, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if (m_rdata !== 32'd3) begin errors++; $display("FAIL errcnt_three: got %0d want 3", m_rdata); end
  endtask

  task automatic test_saturate;
    int cyc;
    int nerr;
    issue(32'hFFF00000, 1'b1, 32'h0);
    wait_rsp(4, cyc);
    nerr = 0;
    for (int i = 0; i < 300; i++) begin
      issue(32'h12300000 + 32'(i * 4), 1'b0, 32'h0);
      wait_rsp(4, cyc);
      if (cyc == 1 && m_err) nerr++;
    end
    checks++;
    if (nerr !== 300) begin errors++; $display("FAIL sat_rsps: got %0d want 300", nerr); end
    issue(32'hFFF00008, 1'b1, 32'hFFFFFFFF);
    wait_rsp(4, cyc);
    issue(32'hFFF00008, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if (m_rdata !== 32'd255) begin errors++; $display("FAIL sat_cnt: got %0d want 255", m_rdata); end
    issue(32'hFFF00000, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if (m_rdata !== 32'd1) begin errors++; $display("FAIL sat_errno: got %0d want 1", m_rdata); end
    issue(32'hFFF00004, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if (m_rdata !== 32'h12300000) begin errors++; $display("FAIL sat_faddr: got %h want 12300000", m_rdata); end
    issue(32'hFFF00000, 1'b1, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if ({cyc[3:0], m_rdata, irq_err} !== {4'd2, 32'h0, 1'b0}) begin
      errors++; $display("FAIL clear2: got cyc=%0d d=%h irq=%b want 2/0/0", cyc, m_rdata, irq_err);
    end
    issue(32'hFFF00008, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if (m_rdata !== 32'd255) begin errors++; $display("FAIL cnt_kept: got %0d want 255", m_rdata); end
  endtask

  task automatic test_reset_mid_wait;
    int cyc;
    bit extra;
    issue(32'h00600000, 1'b0, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if ({m_rsp_valid, s_req_valid, m_req_ready, irq_err} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rst_wait: got v=%b sv=%h rdy=%b irq=%b want 0/00/1/0",
                         m_rsp_valid, s_req_valid, m_req_ready, irq_err);
    end
    reset = 1'b0;
    extra = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (m_rsp_valid) extra = 1'b1;
    end
    checks++;
    if (extra !== 1'b0) begin errors++; $display("FAIL rst_norsp: got response after reset want none"); end
    issue(32'hFFF00008, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    checks++;
    if (m_rdata !== 32'h0) begin errors++; $display("FAIL rst_errcnt: got %0d want 0", m_rdata); end
    s_rdata[0] = 32'h0BADCAFE; s_ack[0] = 1'b1;
    issue(32'h00000010, 1'b0, 32'h0);
    wait_rsp(4, cyc);
    s_ack = '0;
    checks++;
    if ({cyc[3:0], m_err, m_rdata} !== {4'd2, 1'b0, 32'h0BADCAFE}) begin
      errors++; $display("FAIL rst_after: got cyc=%0d e=%b d=%h want 2/0/0badcafe", cyc, m_err, m_rdata);
    end
  endtask

  initial begin
    test_reset;
    test_errcnt_initial;
    test_slave_read;
    test_slave_write;
    test_select_only;
    test_unmapped;
    test_timeout;
    test_saturate;
    test_reset_mid_wait;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
